// File: rtl/tempsens_pkg.sv
// Shared definitions for the temperature-sensor host collector and its responder.
// COLLECTOR_CONTINUOUS_EN adds the SEND_STOP state used by streaming mode.
package tempsens_pkg;

    localparam logic [7:0] START_CODE_DEFAULT = 8'h00;
    localparam logic [7:0] STOP_CODE_DEFAULT  = 8'h01;

    localparam int FRAME_BYTES = 3;

    // Ring-oscillator sums travel least-significant byte first.
    localparam bit BYTE_ORDER_LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_CMD,
        S_RECV_0,
        S_RECV_1,
        S_RECV_2,
        S_DONE
`ifdef COLLECTOR_CONTINUOUS_EN
        , S_SEND_STOP
`endif
    } collector_state_t;

    function automatic logic is_recv_state(input collector_state_t s);
        return (s == S_RECV_0) || (s == S_RECV_1) || (s == S_RECV_2);
    endfunction

endpackage

// File: rtl/rx_frame_assembler.sv
// Holds the received byte slots of one sum frame and exposes the assembled word,
// including a byte arriving this cycle so the caller can register it in one step.
module rx_frame_assembler
    import tempsens_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load,
    input  logic [7:0]                 data,
    output logic [FRAME_BYTES*8-1:0]   frame_word,
    output logic                       frame_complete
);

    logic [7:0] slots [FRAME_BYTES];
    logic [1:0] slot_index;
    logic [1:0] slot_pos;

    always_comb begin
        slot_pos = BYTE_ORDER_LSB_FIRST ? slot_index : (2'(FRAME_BYTES - 1) - slot_index);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                slots[i] <= 8'h00;
            end
            slot_index <= 2'd0;
        end else if (load) begin
            slots[slot_pos] <= data;
            slot_index      <= (slot_index == 2'(FRAME_BYTES - 1)) ? 2'd0 : slot_index + 2'd1;
        end
    end

    // Merge the in-flight byte so the final byte lands in the result without a bubble.
    always_comb begin
        frame_word = '0;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            frame_word[i*8 +: 8] = (load && (slot_pos == 2'(i))) ? data : slots[i];
        end
    end

    assign frame_complete = load && (slot_index == 2'(FRAME_BYTES - 1));

endmodule

// File: rtl/tempsens_result_collector.sv
// Host-side collector: sends the start byte, gathers a 3-byte sum frame with per-byte timeout.
// COLLECTOR_CONTINUOUS_EN: keep collecting frames until stop, then send STOP_CODE.
module tempsens_result_collector
    import tempsens_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  START_CODE     = START_CODE_DEFAULT,
    parameter logic [7:0]  STOP_CODE      = STOP_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        tx_busy,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [23:0] result,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    collector_state_t state;
    logic [TW-1:0]    timer;
    logic             stop_req;
    logic             asm_clear;
    logic             asm_load;
    logic [23:0]      frame_word;
    logic             frame_complete;

`ifdef COLLECTOR_CONTINUOUS_EN
    assign stop_req = stop;
`else
    logic unused_stop;
    assign unused_stop = stop;
    assign stop_req    = 1'b0;
`endif

    assign asm_clear = !is_recv_state(state) && (state != S_DONE);
    assign asm_load  = rx_ready && is_recv_state(state) && !stop_req;
    assign busy      = (state != S_IDLE);

    rx_frame_assembler u_assembler (
        .clk            (clk),
        .reset          (reset),
        .clear          (asm_clear),
        .load           (asm_load),
        .data           (rx_data),
        .frame_word     (frame_word),
        .frame_complete (frame_complete)
    );

    // A command byte goes out on the cycle the state is entered when the UART is idle,
    // so the send state always lasts one cycle beyond the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            tx_send      <= 1'b0;
            tx_data      <= 8'h00;
            result       <= 24'h0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            tx_send      <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            timer        <= (timer == '1) ? timer : timer + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SEND_CMD;
                        timer <= '0;
                        if (!tx_busy) begin
                            tx_send <= 1'b1;
                            tx_data <= START_CODE;
                        end
                    end
                end

                S_SEND_CMD: begin
                    if (tx_send) begin
                        state <= S_RECV_0;
                        timer <= '0;
                    end else if (!tx_busy) begin
                        tx_send <= 1'b1;
                        tx_data <= START_CODE;
                    end
                end

                S_RECV_0, S_RECV_1, S_RECV_2: begin
                    if (stop_req) begin
`ifdef COLLECTOR_CONTINUOUS_EN
                        state <= S_SEND_STOP;
                        timer <= '0;
                        if (!tx_busy) begin
                            tx_send <= 1'b1;
                            tx_data <= STOP_CODE;
                        end
`endif
                    end else if (rx_ready) begin
                        timer <= '0;
                        case (state)
                            S_RECV_0: state <= S_RECV_1;
                            S_RECV_1: state <= S_RECV_2;
                            default:  state <= S_DONE;
                        endcase
                        if (frame_complete) begin
                            result       <= frame_word;
                            result_valid <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        timer       <= '0;
                    end
                end

                S_DONE: begin
                    timer <= '0;
`ifdef COLLECTOR_CONTINUOUS_EN
                    if (stop_req) begin
                        state <= S_SEND_STOP;
                        if (!tx_busy) begin
                            tx_send <= 1'b1;
                            tx_data <= STOP_CODE;
                        end
                    end else begin
                        state <= S_RECV_0;
                    end
`else
                    state <= S_IDLE;
`endif
                end

`ifdef COLLECTOR_CONTINUOUS_EN
                S_SEND_STOP: begin
                    if (tx_send) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end else if (!tx_busy) begin
                        tx_send <= 1'b1;
                        tx_data <= STOP_CODE;
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tempsens_result_collector.sv
// Self-checking bench for tempsens_result_collector with a frame-level reference model.
module tb_tempsens_result_collector;

    localparam int unsigned TIMEOUT = 16;
`ifdef COLLECTOR_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [23:0] result;
    logic        result_valid;
    logic        timeout_err;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model: expected result word and expected pulse totals
    logic [23:0] exp_result = 24'h0;
    int exp_tx = 0;
    int exp_valid = 0;
    int exp_to = 0;

    int tx_count = 0;
    int valid_count = 0;
    int to_count = 0;
    int double_pulses = 0;
    logic prev_tx = 1'b0, prev_valid = 1'b0, prev_to = 1'b0;

    tempsens_result_collector #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .tx_busy      (tx_busy),
        .tx_send      (tx_send),
        .tx_data      (tx_data),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .result       (result),
        .result_valid (result_valid),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_send) tx_count++;
        if (result_valid) valid_count++;
        if (timeout_err) to_count++;
        if ((tx_send && prev_tx) || (result_valid && prev_valid) || (timeout_err && prev_to))
            double_pulses++;
        prev_tx    = tx_send;
        prev_valid = result_valid;
        prev_to    = timeout_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // byte is presented after `gap` idle cycles and sampled by the edge this task returns after
    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = $urandom_range(255, 0);
    endtask

    // leaves the bench just after the edge where the command strobe should be visible
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_tx++;
    endtask

    task automatic return_to_idle();
        if (CONT) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            exp_tx++;
            idle(2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        tests_run += 6;
        if (tx_send !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_send got %b want 0", tx_send); end
        if (tx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
        if (result !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_result got %h want 000000", result); end
        if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", result_valid); end
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout got %b want 0", timeout_err); end
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        pulse_start();
        tests_run += 2;
        if (tx_send !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_tx_send got %b want 1", tx_send); end
        if (tx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL basic_tx_data got %h want 00", tx_data); end
        tick();
        tests_run += 2;
        if (tx_send !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_tx_once got %b want 0", tx_send); end
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        send_byte(8'h34, 0);
        send_byte(8'h12, 2);
        send_byte(8'h00, 1);
        exp_result = 24'h001234;
        exp_valid++;
        tests_run += 2;
        if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid got %b want 1", result_valid); end
        if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL basic_result got %h want %h", result, exp_result); end
        tick();
        tests_run += 2;
        if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_valid_width got %b want 0", result_valid); end
        if (busy !== CONT) begin tests_failed++; $display("[TB] FAIL basic_busy_after got %b want %b", busy, CONT); end
        return_to_idle();
    endtask

    task automatic test_back_pressure();
        int early = 0;
        logic [7:0] b0, b1, b2;
        tx_busy = 1'b1;
        pulse_start();
        for (int i = 0; i < 49; i++) begin
            if (tx_send) early++;
            tick();
        end
        if (tx_send) early++;
        tx_busy = 1'b0;
        tick();
        tests_run += 3;
        if (early != 0) begin tests_failed++; $display("[TB] FAIL bp_early_send got %0d want 0", early); end
        if (tx_send !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_tx_send got %b want 1", tx_send); end
        if (tx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL bp_tx_data got %h want 00", tx_data); end
        tick();
        b0 = $urandom_range(255, 0);
        b1 = $urandom_range(255, 0);
        b2 = $urandom_range(255, 0);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
        exp_result = {b2, b1, b0};
        exp_valid++;
        tests_run++;
        if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL bp_result got %h want %h", result, exp_result); end
        tick();
        return_to_idle();
    endtask

    task automatic test_random_frames();
        logic [7:0] b [3];
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 3; k++) b[k] = $urandom_range(255, 0);
            pulse_start();
            tests_run++;
            if (tx_send !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd_tx_send frame %0d got %b want 1", f, tx_send); end
            tick();
            send_byte(b[0], $urandom_range(12, 0));
            send_byte(b[1], $urandom_range(12, 0));
            tests_run++;
            if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL rnd_partial frame %0d got %h want %h", f, result, exp_result); end
            send_byte(b[2], $urandom_range(12, 0));
            exp_result = {b[2], b[1], b[0]};
            exp_valid++;
            tests_run += 2;
            if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd_valid frame %0d got %b want 1", f, result_valid); end
            if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL rnd_result frame %0d got %h want %h", f, result, exp_result); end
            tick();
            return_to_idle();
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        pulse_start();
        tick();
        send_byte($urandom_range(255, 0), 0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (timeout_err) early++;
        end
        tick();
        exp_to++;
        tests_run += 4;
        if (early != 0) begin tests_failed++; $display("[TB] FAIL to_early got %0d want 0", early); end
        if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_pulse got %b want 1", timeout_err); end
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_busy got %b want 0", busy); end
        if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL to_result got %h want %h", result, exp_result); end
        tick();
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_width got %b want 0", timeout_err); end
    endtask

    task automatic test_race();
        logic [7:0] b0, b1, b2;
        b0 = $urandom_range(255, 0);
        b1 = $urandom_range(255, 0);
        b2 = $urandom_range(255, 0);
        pulse_start();
        tick();
        send_byte(b0, 0);
        send_byte(b1, TIMEOUT - 1);
        tests_run += 2;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL race_timeout got %b want 0", timeout_err); end
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL race_busy got %b want 1", busy); end
        send_byte(b2, TIMEOUT - 1);
        exp_result = {b2, b1, b0};
        exp_valid++;
        tests_run += 2;
        if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL race_valid got %b want 1", result_valid); end
        if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL race_result got %h want %h", result, exp_result); end
        tick();
        return_to_idle();
    endtask

    task automatic test_reset_midframe();
        pulse_start();
        tick();
        send_byte($urandom_range(255, 0), 0);
        send_byte($urandom_range(255, 0), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_result = 24'h0;
        tests_run += 3;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
        if (result !== 24'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_result got %h want 000000", result); end
        if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_valid got %b want 0", result_valid); end
        tick();
        pulse_start();
        tick();
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        exp_result = 24'hFFFFFF;
        exp_valid++;
        tests_run++;
        if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL rst_mid_frame got %h want %h", result, exp_result); end
        tick();
        return_to_idle();
    endtask

`ifdef COLLECTOR_CONTINUOUS_EN
    task automatic test_continuous();
        logic [7:0] b [6];
        int v0;
        for (int k = 0; k < 6; k++) b[k] = $urandom_range(255, 0);
        v0 = valid_count;
        pulse_start();
        tick();
        for (int f = 0; f < 2; f++) begin
            send_byte(b[3*f], 1);
            send_byte(b[3*f+1], 0);
            send_byte(b[3*f+2], 2);
            exp_result = {b[3*f+2], b[3*f+1], b[3*f]};
            exp_valid++;
            tests_run++;
            if (result !== exp_result) begin tests_failed++; $display("[TB] FAIL cont_result frame %0d got %h want %h", f, result, exp_result); end
        end
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp_tx++;
        tests_run += 3;
        if (valid_count - v0 != 2) begin tests_failed++; $display("[TB] FAIL cont_valids got %0d want 2", valid_count - v0); end
        if (tx_send !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_stop_send got %b want 1", tx_send); end
        if (tx_data !== 8'h01) begin tests_failed++; $display("[TB] FAIL cont_stop_data got %h want 01", tx_data); end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_idle got %b want 0", busy); end
        tick();
    endtask
`endif

    task automatic test_event_counts();
        idle(2);
        tests_run += 4;
        if (tx_count != exp_tx) begin tests_failed++; $display("[TB] FAIL count_tx got %0d want %0d", tx_count, exp_tx); end
        if (valid_count != exp_valid) begin tests_failed++; $display("[TB] FAIL count_valid got %0d want %0d", valid_count, exp_valid); end
        if (to_count != exp_to) begin tests_failed++; $display("[TB] FAIL count_timeout got %0d want %0d", to_count, exp_to); end
        if (double_pulses != 0) begin tests_failed++; $display("[TB] FAIL double_pulse got %0d want 0", double_pulses); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_random_frames();
        test_timeout();
        test_race();
        test_reset_midframe();
`ifdef COLLECTOR_CONTINUOUS_EN
        test_continuous();
`endif
        test_event_counts();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tempsens_result_collector.md
# tempsens_result_collector

Host-side counterpart of the on-chip temperature-sensor command/response controller. It issues the start command byte over UART, then receives and reassembles the three-byte ring-oscillator sum frame (LSB first) into a 24-bit result. It has a per-byte timeout for lost bytes. It sits between a standard UART TX/RX pair and host logic (FPGA test harness or self-test wrapper) and presents one `result_valid` pulse per complete frame.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum clk cycles allowed between consecutive expected bytes; must be ≥ 2.
- `START_CODE`, default 8'h00: command byte that starts a measurement.
- `STOP_CODE`, default 8'h01: any non-start byte; returns the responder to idle.
- `clk`  in  1  system clock; one clock domain, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a measurement.
- `stop`  in  1  one-cycle request to send STOP_CODE; only acted on with COLLECTOR_CONTINUOUS_EN.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_send`  out  1  one-cycle strobe to transmit `tx_data`.
- `tx_data`  out  8  byte to transmit.
- `rx_ready`  in  1  one-cycle strobe: `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `result`  out  24  last complete sum, {byte2, byte1, byte0}.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `timeout_err`  out  1  one-cycle pulse on byte timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND_CMD, RECV_0, RECV_1, RECV_2, DONE; with the macro, also SEND_STOP.
- IDLE: `start`=1 → SEND_CMD. `rx_ready` is ignored.
- SEND_CMD: waits while `tx_busy`=1. When `tx_busy`=0, drive `tx_send`=1 and `tx_data`=START_CODE for exactly one cycle, then go to RECV_0.
- RECV_n (n=0..2): on `rx_ready`, latch `rx_data` into byte slot n and advance to RECV_n+1. From RECV_2, advance to DONE.
- DONE: for one cycle, load `result` from the three slots and pulse `result_valid`. Next state is IDLE; with the macro, RECV_0.
- Timeout: `timer` clears on every state change. In RECV_n, if `timer` reaches TIMEOUT_CYCLES-1 with `rx_ready`=0, pulse `timeout_err` and go to IDLE. If `rx_ready` arrives on that same cycle, the byte wins.
- `result` changes only in DONE; partial frames never corrupt it.
- `start` while `busy`=1 is ignored.
- Reset mid-frame: state goes to IDLE; slots and `result` clear to 0; no pulses.

## Timing
- Reset values: `tx_send`=0, `tx_data`=8'h00, `result`=24'h0, `result_valid`=0, `timeout_err`=0, `busy`=0.
- `start` at cycle t with `tx_busy`=0: `tx_send` high at t+1, RECV_0 at t+2.
- Third `rx_ready` at cycle r: `result_valid` is high at r+1, and `result` is already valid in that same cycle.
- `tx_send`, `result_valid` and `timeout_err` are registered and never high for two consecutive cycles.
- Timer width: $clog2(TIMEOUT_CYCLES); saturates and never wraps.

## Configuration
- `COLLECTOR_CONTINUOUS_EN` defined:
  - After DONE, return to RECV_0 and collect the next frame; the responder streams repeatedly.
  - `stop` in any RECV_n or DONE state → SEND_STOP. SEND_STOP sends STOP_CODE under the same `tx_busy` rule as SEND_CMD, then goes to IDLE and discards any partial frame.
  - Timeout still goes to IDLE.
- Not defined: single-shot; DONE → IDLE, the `stop` input is unused, and there is no SEND_STOP state.

## Structure
- Shared package `tempsens_pkg`:
  - `START_CODE`/`STOP_CODE` defaults.
  - `FRAME_BYTES`=3.
  - Collector state enum.
  - The same byte-order constant the responder uses (LSB first).
- One sub-module, `rx_frame_assembler`: the three byte slots, slot index, load-on-`rx_ready`, and clear. The FSM and timeout counter stay in the top module.

## Test plan
- Basic frame: `start`, then bytes 8'h34, 8'h12, 8'h00 → one `tx_send` with `tx_data`=8'h00, then `result`=24'h001234 and `result_valid` one cycle after the third byte.
- TX back-pressure: `tx_busy` held high for 50 cycles after `start` → `tx_send` occurs exactly once, on the first cycle `tx_busy`=0.
- Timeout: TIMEOUT_CYCLES=16, only one byte sent → `timeout_err` pulses 16 cycles after entering RECV_1; `result` keeps its previous value; `busy`=0 afterwards.
- Race: `rx_ready` coincides with the timeout cycle → byte accepted, no `timeout_err`.
- Reset mid-frame after two bytes, then a full frame 8'hFF, 8'hFF, 8'hFF → `result`=24'hFFFFFF; no stale bytes.
- Continuous (macro on): two back-to-back frames, then `stop` → two `result_valid` pulses, then `tx_send` with `tx_data`=8'h01, then IDLE.
